// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus bit constants shared by the I2C target
// register file and its bench.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_in_filter.sv
// i2c_in_filter: 2-flop synchroniser plus a FILT_LEN-sample glitch filter
// for one bus line, with one-cycle rise/fall pulses of the filtered level.
module i2c_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]          sync;
  logic [FILT_LEN-1:0] hist;

  // The level only moves once the last FILT_LEN synchronised samples agree;
  // rise/fall are registered alongside so they line up with the new level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      hist  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      hist <= FILT_LEN'({hist, sync[1]});
      rise <= 1'b0;
      fall <= 1'b0;
      if (hist == '1 && !level) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (hist == '0 && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing NUM_REGS 8-bit registers through an
// auto-incrementing pointer, plus a host-side combinational read / write port.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int FILT_LEN = 3,
  localparam int PTR_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       addr,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] hrd_addr,
  output logic [7:0]       hrd_data,
  input  logic             hwr_en,
  input  logic [PTR_W-1:0] hwr_addr,
  input  logic [7:0]       hwr_data,
  output logic             wr_strb,
  output logic [PTR_W-1:0] wr_idx,
  output logic [7:0]       wr_val,
  output logic             busy,
  output logic             done
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_e       state_q, state_d;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic             rw_q;
  logic             mack_q;
  logic [PTR_W-1:0] ptr;
  logic             oe_d;
  logic [7:0]       regs [NUM_REGS];

  logic             start_det, stop_det;
  logic             byte_done, addr_match, ptr_ok, wr_fire;
  logic [7:0]       byte_in;
  logic [PTR_W-1:0] ptr_inc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign start_det  = sda_fall & scl;
  assign stop_det   = sda_rise & scl;
  assign byte_done  = (bit_cnt == I2C_BYTE_BITS);
  assign byte_in    = {shift[6:0], sda};
  assign addr_match = (shift[7:1] == addr);
  assign ptr_ok     = ({1'b0, shift} < 9'(NUM_REGS));
  assign ptr_inc    = next_ptr(ptr);
  assign wr_fire    = !start_det && !stop_det && scl_rise &&
                      (state_q == ST_WDATA) && (bit_cnt == 4'd7);
  assign hrd_data   = regs[hrd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next SDA drive; SDA only moves on a filtered SCL fall,
  // except that START/STOP always release it.
  always_comb begin
    state_d = state_q;
    oe_d    = sda_oe;
    if (start_det) begin
      state_d = ST_ADDR;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            state_d = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
            oe_d    = addr_match;
          end
        end
        ST_ADDR_ACK: begin
          if (rw_q == I2C_RW_READ) begin
            state_d = ST_RDATA;
            oe_d    = ~regs[ptr][7];
          end else begin
            state_d = ST_PTR;
            oe_d    = 1'b0;
          end
        end
        ST_PTR: begin
          if (byte_done) begin
            state_d = ptr_ok ? ST_PTR_ACK : ST_WAIT_STOP;
            oe_d    = ptr_ok;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          state_d = ST_WDATA;
          oe_d    = 1'b0;
        end
        ST_WDATA: begin
          if (byte_done) begin
            state_d = ST_WDATA_ACK;
            oe_d    = 1'b1;
          end
        end
        ST_RDATA: begin
          if (byte_done) begin
            state_d = ST_RDATA_ACK;
            oe_d    = 1'b0;
          end else begin
            oe_d = ~shift[7];
          end
        end
        ST_RDATA_ACK: begin
          if (mack_q == I2C_ACK) begin
            state_d = ST_RDATA;
            oe_d    = ~regs[ptr_inc][7];
          end else begin
            state_d = ST_WAIT_STOP;
            oe_d    = 1'b0;
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  // Bit counting, shifting, pointer and status; the read byte is copied into
  // shift when its first bit goes out, so later host writes cannot tear it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      rw_q    <= I2C_RW_WRITE;
      mack_q  <= I2C_NACK;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_strb <= 1'b0;
      wr_idx  <= '0;
      wr_val  <= '0;
    end else begin
      sda_oe  <= oe_d;
      done    <= 1'b0;
      wr_strb <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt <= '0;
        done    <= busy;
        busy    <= 1'b0;
      end else begin
        if (scl_rise) begin
          case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
            end
            ST_RDATA:     bit_cnt <= bit_cnt + 4'd1;
            ST_RDATA_ACK: mack_q  <= sda;
            default: ;
          endcase
        end
        if (wr_fire) begin
          wr_strb <= 1'b1;
          wr_idx  <= ptr;
          wr_val  <= byte_in;
        end
        if (scl_fall) begin
          case (state_q)
            ST_ADDR: begin
              if (byte_done) begin
                rw_q    <= shift[0];
                bit_cnt <= '0;
                busy    <= addr_match;
              end
            end
            ST_ADDR_ACK: begin
              bit_cnt <= '0;
              if (rw_q == I2C_RW_READ) shift <= {regs[ptr][6:0], 1'b0};
            end
            ST_PTR: begin
              if (byte_done) begin
                bit_cnt <= '0;
                if (ptr_ok) ptr <= shift[PTR_W-1:0];
              end
            end
            ST_PTR_ACK, ST_WDATA_ACK: bit_cnt <= '0;
            ST_WDATA: begin
              if (byte_done) ptr <= ptr_inc;
            end
            ST_RDATA: begin
              if (!byte_done) shift <= {shift[6:0], 1'b0};
            end
            ST_RDATA_ACK: begin
              bit_cnt <= '0;
              if (mack_q == I2C_ACK) begin
                ptr   <= ptr_inc;
                shift <= {regs[ptr_inc][6:0], 1'b0};
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Register array; the I2C write is applied last so it wins a same-cycle
  // collision with the host port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      if (hwr_en)  regs[hwr_addr] <= hwr_data;
      if (wr_fire) regs[ptr]      <= byte_in;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bit-banged I2C master with a scoreboard of expected
// register writes, done pulses and bus responses (ACK bits, read bytes).
module tb_i2c_target_regfile;

  localparam int NUM_REGS = 16;
  localparam int FILT_LEN = 3;
  localparam int PTR_W    = 4;
  localparam int T        = 10;

  typedef struct packed {
    logic       is_rd;
    logic [7:0] data;
  } bus_item_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       addr = 7'h42;
  logic             scl_i = 1'b1;
  logic             sda_m = 1'b1;
  logic             sda_i;
  logic             sda_oe;
  logic [PTR_W-1:0] hrd_addr = '0;
  logic [7:0]       hrd_data;
  logic             hwr_en = 1'b0;
  logic [PTR_W-1:0] hwr_addr = '0;
  logic [7:0]       hwr_data = '0;
  logic             wr_strb;
  logic [PTR_W-1:0] wr_idx;
  logic [7:0]       wr_val;
  logic             busy;
  logic             done;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_wr_q [$];
  bus_item_t   exp_bus_q [$];
  int          exp_done = 0;
  bus_item_t   rsp_item;
  logic        rsp_valid = 1'b0;
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;

  // Open-drain SDA: the line is low if either side pulls it.
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(.NUM_REGS(NUM_REGS), .FILT_LEN(FILT_LEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .hrd_addr (hrd_addr),
    .hrd_data (hrd_data),
    .hwr_en   (hwr_en),
    .hwr_addr (hwr_addr),
    .hwr_data (hwr_data),
    .wr_strb  (wr_strb),
    .wr_idx   (wr_idx),
    .wr_val   (wr_val),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic post_rsp(input logic is_rd, input logic [7:0] d);
    @(posedge clk);
    rsp_item  = '{is_rd, d};
    rsp_valid = 1'b1;
    @(posedge clk);
    rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b0;
    wait_cyc(T);
    scl_i = 1'b0;
  endtask

  task automatic bus_restart();
    wait_cyc(T); sda_m = 1'b1;
    wait_cyc(T); scl_i = 1'b1;
    wait_cyc(T); sda_m = 1'b0;
    wait_cyc(T); scl_i = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(T); sda_m = 1'b0;
    wait_cyc(T); scl_i = 1'b1;
    wait_cyc(T); sda_m = 1'b1;
    wait_cyc(T);
  endtask

  task automatic drive_bit(input logic b, input logic glitch);
    wait_cyc(T);
    sda_m = b;
    if (glitch) begin
      wait_cyc(T / 2); scl_i = 1'b1;
      wait_cyc(1);     scl_i = 1'b0;
      wait_cyc(T / 2);
    end else begin
      wait_cyc(T);
    end
    scl_i = 1'b1;
    wait_cyc(T);
    scl_i = 1'b0;
  endtask

  task automatic clock_in_bit(output logic b);
    wait_cyc(T); sda_m = 1'b1;
    wait_cyc(T); scl_i = 1'b1;
    wait_cyc(T); b = sda_i;
    scl_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input int glitch_bit = -1);
    logic a;
    exp_bus_q.push_back('{1'b0, {7'd0, exp_ack}});
    for (int i = 7; i >= 0; i--) drive_bit(b[i], i == glitch_bit);
    clock_in_bit(a);
    post_rsp(1'b0, {7'd0, a});
  endtask

  task automatic recv_byte(input logic [7:0] exp_byte, input logic mack);
    logic [7:0] d;
    logic       b;
    exp_bus_q.push_back('{1'b1, exp_byte});
    for (int i = 7; i >= 0; i--) begin
      clock_in_bit(b);
      d[i] = b;
    end
    post_rsp(1'b1, d);
    drive_bit(mack, 1'b0);
  endtask

  task automatic host_write(input logic [PTR_W-1:0] idx, input logic [7:0] d);
    hwr_addr = idx;
    hwr_data = d;
    hwr_en   = 1'b1;
    wait_cyc(1);
    hwr_en   = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [PTR_W-1:0] idx, input logic [7:0] exp);
    hrd_addr = idx;
    wait_cyc(1);
    check_output(name, hrd_data, exp);
  endtask

  // Monitor: pops the matching expectation whenever the DUT or the bus
  // presents a response.
  always @(negedge clk) begin
    if (wr_strb) begin
      check_output("wr_strb expected", exp_wr_q.size() > 0, 1);
      if (exp_wr_q.size() > 0) check_output("wr_strb idx/val", {wr_idx, wr_val}, exp_wr_q.pop_front());
    end
    if (done) begin
      check_output("done expected", exp_done > 0, 1);
      if (exp_done > 0) exp_done--;
    end
    if (rsp_valid) begin
      check_output("bus rsp expected", exp_bus_q.size() > 0, 1);
      if (exp_bus_q.size() > 0) check_output("bus ack/read byte", rsp_item, exp_bus_q.pop_front());
    end
    if (sda_oe) oe_seen <= 1'b1;
    if (busy)   busy_seen <= 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic b;

    $display("[TB] reset");
    wait_cyc(5);
    check_output("reset sda_oe", sda_oe, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset wr_strb", wr_strb, 0);
    check_reg("reset reg0", 4'd0, 8'h00);
    rst_n = 1'b1;
    wait_cyc(20);

    $display("[TB] write 0xA5,0x5A from ptr 3");
    bus_start();
    send_byte(8'h84, 1'b0);
    check_output("busy after addr ack", busy, 1);
    send_byte(8'h03, 1'b0);
    exp_wr_q.push_back({4'd3, 8'hA5});
    send_byte(8'hA5, 1'b0);
    exp_wr_q.push_back({4'd4, 8'h5A});
    send_byte(8'h5A, 1'b0);
    exp_done++;
    bus_stop();
    wait_cyc(20);
    check_output("busy after stop", busy, 0);
    check_reg("reg3 after write", 4'd3, 8'hA5);
    check_reg("reg4 after write", 4'd4, 8'h5A);

    $display("[TB] ptr 0x0F, Sr, read 3 bytes with wrap");
    host_write(4'd15, 8'hF1);
    host_write(4'd0, 8'h10);
    host_write(4'd1, 8'h11);
    bus_start();
    send_byte(8'h84, 1'b0);
    send_byte(8'h0F, 1'b0);
    exp_done++;
    bus_restart();
    send_byte(8'h85, 1'b0);
    recv_byte(8'hF1, 1'b0);
    recv_byte(8'h10, 1'b0);
    recv_byte(8'h11, 1'b1);
    exp_done++;
    bus_stop();
    wait_cyc(20);

    $display("[TB] foreign address 0x43");
    oe_seen   = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    send_byte(8'h86, 1'b1);
    send_byte(8'h00, 1'b1);
    bus_stop();
    wait_cyc(20);
    check_output("foreign addr sda never driven", oe_seen, 0);
    check_output("foreign addr busy stays 0", busy_seen, 0);

    $display("[TB] out-of-range ptr 0x20");
    bus_start();
    send_byte(8'h84, 1'b0);
    send_byte(8'h20, 1'b1);
    send_byte(8'h77, 1'b1);
    exp_done++;
    bus_stop();
    wait_cyc(20);
    bus_start();
    send_byte(8'h85, 1'b0);
    recv_byte(8'h11, 1'b1);
    exp_done++;
    bus_stop();
    wait_cyc(20);

    $display("[TB] SCL glitch, then STOP mid-byte");
    bus_start();
    send_byte(8'h84, 1'b0);
    send_byte(8'h02, 1'b0, 3);
    exp_wr_q.push_back({4'd2, 8'h3C});
    send_byte(8'h3C, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    exp_done++;
    bus_stop();
    wait_cyc(20);
    check_output("mid-byte stop sda_oe", sda_oe, 0);
    check_output("mid-byte stop busy", busy, 0);
    check_reg("reg2 after glitch write", 4'd2, 8'h3C);

    $display("[TB] host/I2C collision on reg2");
    bus_start();
    send_byte(8'h84, 1'b0);
    send_byte(8'h02, 1'b0);
    hwr_addr = 4'd2;
    hwr_data = 8'h66;
    hwr_en   = 1'b1;
    exp_wr_q.push_back({4'd2, 8'h99});
    fork
      send_byte(8'h99, 1'b0);
      begin
        for (int i = 0; i < 2000 && !wr_strb; i++) @(negedge clk);
        hwr_en = 1'b0;
      end
    join
    exp_done++;
    bus_stop();
    wait_cyc(20);
    check_reg("reg2 I2C wins collision", 4'd2, 8'h99);

    $display("[TB] reset mid-read");
    bus_start();
    send_byte(8'h85, 1'b0);
    clock_in_bit(b);
    wait_cyc(T);
    check_output("sda_oe driving read bit", sda_oe, 1);
    rst_n = 1'b0;
    wait_cyc(1);
    check_output("sda_oe released after reset", sda_oe, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    check_output("busy after mid-read reset", busy, 0);
    check_reg("reg3 cleared by reset", 4'd3, 8'h00);
    bus_stop();
    wait_cyc(20);
    host_write(4'd0, 8'hC3);
    host_write(4'd3, 8'h77);
    bus_start();
    send_byte(8'h85, 1'b0);
    recv_byte(8'hC3, 1'b1);
    exp_done++;
    bus_stop();
    wait_cyc(50);

    check_output("pending wr_strb expectations", exp_wr_q.size(), 0);
    check_output("pending bus expectations", exp_bus_q.size(), 0);
    check_output("pending done expectations", exp_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning the number of 8-bit registers (2..256); PTR_W = clog2(NUM_REGS).
REQ-002 SHALL have parameter FILT_LEN, default 3, meaning the SCL/SDA glitch-filter length in clk cycles (1..8).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port addr  in  7  own target address, sampled at the address ACK bit.
REQ-006 SHALL have ports scl_i  in  1 and sda_i  in  1: raw bus levels, asynchronous.
REQ-007 SHALL have port sda_oe  out  1  1 = pull SDA low, 0 = release; pad is open-drain, with no SDA data-out port.
REQ-008 SHALL have ports hrd_addr  in  PTR_W and hrd_data  out  8: host combinational read of the register array.
REQ-009 SHALL have ports hwr_en  in  1, hwr_addr  in  PTR_W and hwr_data  in  8: host write port.
REQ-010 SHALL have ports wr_strb  out  1, wr_idx  out  PTR_W and wr_val  out  8: one-cycle pulse per register written over I2C.
REQ-011 SHALL have ports busy  out  1 (addressed transaction in progress) and done  out  1 (one-cycle pulse at STOP/Sr ending an addressed transaction).

Function
REQ-012 SHALL pass scl_i/sda_i through a 2-flop synchroniser, then a filter that updates a level only after FILT_LEN consecutive equal samples.
REQ-013 SHALL derive scl_rise/scl_fall/sda_rise/sda_fall as one-cycle pulses from the filtered levels.
REQ-014 SHALL detect START (including Sr) as sda_fall while filtered SCL = 1, and STOP as sda_rise while SCL = 1, in every state; either event overrides the current state.
REQ-015 SHALL sample SDA on scl_rise, and SHALL change sda_oe only in the cycle after scl_fall.
REQ-016 SHALL implement the states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and WAIT_STOP.
REQ-017 SHALL go from IDLE, or any state, on START to ADDR with the bit counter cleared; STOP goes to IDLE with sda_oe = 0.
REQ-018 SHALL, in ADDR after 8 bits, ACK (sda_oe = 1 for the ACK clock) if bits[7:1] == addr; otherwise go to WAIT_STOP with the bus released.
REQ-019 SHALL go from ADDR_ACK on R/W = 0 to PTR, and on R/W = 1 to RDATA, driving the MSB of reg[ptr] after the ACK scl_fall.
REQ-020 SHALL, in PTR, load the pointer if the byte is < NUM_REGS and ACK; otherwise NACK and go to WAIT_STOP with the pointer unchanged.
REQ-021 SHALL, per WDATA byte, write reg[ptr], pulse wr_strb (wr_idx = ptr, wr_val = byte) on the 8th scl_rise, ACK, and post-increment ptr modulo NUM_REGS (wrap to 0).
REQ-022 SHALL, in RDATA, shift out reg[ptr] MSB first (sda_oe = ~bit); the byte is captured at its first bit so that concurrent host writes do not corrupt it.
REQ-023 SHALL, in RDATA_ACK, release SDA; master ACK -> ptr+1 (wrap) and next byte; master NACK -> WAIT_STOP.
REQ-024 SHALL retain the pointer across transactions; a write of only the pointer followed by Sr+read SHALL read from the new pointer.
REQ-025 SHALL give I2C precedence when an I2C write and hwr_en hit the same register in the same cycle; the host write is dropped.
REQ-026 SHALL assert busy from the address ACK until STOP/Sr, and pulse done on that STOP/Sr.

Reset
REQ-027 SHALL, with rst_n = 0, set state = IDLE, sda_oe = 0, ptr = 0, all registers = 0x00, wr_strb = done = busy = 0, and filter levels = 1.
REQ-028 SHALL, on reset asserted mid-transaction, release SDA in the next cycle and ignore the bus until the next START.

Structure
REQ-029 SHALL place the state encoding and the I2C R/W/ACK bit constants in shared package i2c_pkg.
REQ-030 SHALL instantiate sub-module i2c_in_filter (synchroniser + FILT_LEN filter + edge pulses) once per bus line.

Verification
REQ-031 SHALL cover: addr = 0x42, write 0x84, ptr 0x03, data 0xA5, 0x5A -> two ACKs after data, reg[3] = 0xA5, reg[4] = 0x5A, two wr_strb pulses, done at STOP.
REQ-032 SHALL cover: ptr write 0x0F with NUM_REGS = 16, then Sr, read 0x85 of 3 bytes (ACK, ACK, NACK) -> bytes from reg[15], reg[0], reg[1].
REQ-033 SHALL cover: address 0x43 when addr = 0x42 -> SDA never driven, no wr_strb, busy stays 0.
REQ-034 SHALL cover: ptr byte 0x20 with NUM_REGS = 16 -> NACK, ptr unchanged, subsequent data ignored.
REQ-035 SHALL cover: a 1-cycle SCL glitch with FILT_LEN = 3 -> no bit shifted; STOP mid-byte -> IDLE, sda_oe = 0.
REQ-036 SHALL cover: hwr_en to reg[2] in the same cycle as an I2C write to reg[2] -> the I2C value is retained; rst_n low mid-read -> SDA released the next cycle.
